video_timing_gen: RTL
=====================

// Module: video_timing_gen
// PURPOSE
//  Parametrised successor to the pixel counters. Generates h/v counts plus hsync, vsync, de,
//  line_start and frame_start from a programmable timing set. The timing set is shadowed and
//  only changes at a frame boundary. Sits between the pixel clock domain and the HDMI/TMDS
//  encoder/pattern path.
// PARAMETERS
//  CW       12   counter and timing-field width, in bits
//  H_TOT_D  800  reset value of h_total shadow (640x480@60 defaults throughout)
//  H_ACT_D  640  reset value of h_active shadow
//  H_SS_D   656  reset value of h_sync_start shadow
//  H_SE_D   752  reset value of h_sync_end shadow
//  V_TOT_D  525  reset value of v_total shadow
//  V_ACT_D  480  reset value of v_active shadow
//  V_SS_D   490  reset value of v_sync_start shadow
//  V_SE_D   492  reset value of v_sync_end shadow
//  HS_POL_D 0    reset hsync polarity (1 = active high)
//  VS_POL_D 0    reset vsync polarity (1 = active high)
// PORTS
//  pixel_clk                in   1   pixel clock; one clock domain only
//  rst_n                    in   1   asynchronous active-low reset
//  enable                   in   1   1 = advance counters; 0 = freeze
//  h_total,h_active         in   CW  new horizontal total / active width
//  h_sync_start,h_sync_end  in   CW  new hsync window [start,end)
//  v_total,v_active         in   CW  new vertical total / active height
//  v_sync_start,v_sync_end  in   CW  new vsync window [start,end), in lines
//  hs_pol,vs_pol            in   1   new sync polarities
//  cfg_update               in   1   1-cycle request to load the inputs above
//  h_count,v_count          out  CW  current pixel / line position
//  hsync,vsync,de           out  1   sync and data-enable, aligned with the counts
//  line_start               out  1   1 for one cycle when h_count==0
//  frame_start              out  1   1 for one cycle when h_count==0 && v_count==0
//  cfg_pending              out  1   request accepted, waiting for the frame boundary
//  cfg_err                  out  1   sticky: last load rejected; cleared by the next valid load
// BEHAVIOUR
//  - Reset: shadows <= *_D params.
//    Count and strobe outputs: h_count=H_TOT_D-1, v_count=V_TOT_D-1, de=0,
//    line_start=0, frame_start=0.
//    Sync outputs: hsync=~HS_POL_D, vsync=~VS_POL_D.
//    Flags: cfg_pending=0, cfg_err=0.
//    The first enabled edge therefore wraps to (0,0) and asserts frame_start.
//  - All outputs are registered and computed from the next count value.
//    hsync, vsync, de and the strobes are cycle-aligned with h_count/v_count (0 lag).
//  - Counting uses compares, never modulo, against the shadow totals:
//    h wraps to 0 when h_count==h_total-1; otherwise h+1.
//    v advances only on an h wrap; v wraps to 0 when v_count==v_total-1.
//  - Sync, active when asserted = pol:
//    hsync = pol when h in [h_ss,h_se), else ~pol; same rule for vsync on v only.
//    vsync therefore changes only together with h_count==0.
//  - de = (h<h_active) && (v<v_active).
//  - enable=0: counts, hsync, vsync and de hold their values;
//    line_start and frame_start are forced 0; cfg_pending still sets.
//  - cfg_update sets cfg_pending. The inputs are sampled in the cycle the counters wrap
//    to (0,0), and only if cfg_pending is set or cfg_update is high in that same cycle.
//    The new timing governs that (0,0) cycle's outputs, and cfg_pending clears.
//  - Validity check at load: total>=2, 1<=active<=total, sync_start<sync_end<=total,
//    for both axes.
//    Valid: shadows load and cfg_err <= 0.
//    Invalid: shadows unchanged and cfg_err <= 1.
//    In both cases cfg_pending clears.
//  - cfg_update while pending: request stays single; the latest input values are used.
//  - Reset asserted mid-frame: immediately returns all state to the reset values above.
// TESTING
//  1. Reset, enable=1 -> 1st edge (0,0), frame_start=1 and line_start=1;
//     frame_start period = 800*525 = 420000 cycles.
//  2. Defaults -> hsync=0 exactly for h 656..751; de=1 for h<640 && v<480;
//     vsync=0 exactly for v 490..491.
//  3. cfg_update mid-frame with 1280x720 timing (1650/1280/1390/1430, 750/720/725/730, pol=1)
//     -> old timing runs to frame end; new timing from the next (0,0); cfg_pending 1 then 0.
//  4. cfg_update with h_sync_end=900 > h_total=800 -> at the boundary cfg_err=1 and the
//     timing is unchanged; a later valid load clears cfg_err.
//  5. enable=0 for 10 cycles at h=100 -> h_count holds 100 with strobes 0;
//     after re-enable the next value is 101.
//  6. rst_n pulse low at v=300 -> outputs return to the reset values asynchronously;
//     after release the sequence restarts as in scenario 1.

Source files
------------

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: h/v counters, sync, data enable and strobes.
// The timing set is held in shadow registers that are reloaded only when the raster wraps to (0,0).
module video_timing_gen #(
  parameter int CW       = 12,
  parameter int H_TOT_D  = 800,
  parameter int H_ACT_D  = 640,
  parameter int H_SS_D   = 656,
  parameter int H_SE_D   = 752,
  parameter int V_TOT_D  = 525,
  parameter int V_ACT_D  = 480,
  parameter int V_SS_D   = 490,
  parameter int V_SE_D   = 492,
  parameter bit HS_POL_D = 1'b0,
  parameter bit VS_POL_D = 1'b0
) (
  input  logic          pixel_clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [CW-1:0] h_total,
  input  logic [CW-1:0] h_active,
  input  logic [CW-1:0] h_sync_start,
  input  logic [CW-1:0] h_sync_end,
  input  logic [CW-1:0] v_total,
  input  logic [CW-1:0] v_active,
  input  logic [CW-1:0] v_sync_start,
  input  logic [CW-1:0] v_sync_end,
  input  logic          hs_pol,
  input  logic          vs_pol,
  input  logic          cfg_update,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start,
  output logic          cfg_pending,
  output logic          cfg_err
);

  // One timing set per axis; index 0 is horizontal, index 1 is vertical.
  typedef struct packed {
    logic [CW-1:0] tot;
    logic [CW-1:0] act;
    logic [CW-1:0] ss;
    logic [CW-1:0] se;
    logic          pol;
  } axis_t;

  axis_t         cfg_in  [2];
  axis_t         shd_q   [2];
  axis_t         shd_d   [2];
  logic [CW-1:0] pos_nx  [2];
  logic [1:0]    axis_ok;
  logic [1:0]    sync_nx;
  logic [1:0]    in_act;

  logic [CW-1:0] h_q, h_d, v_q, v_d, h_nx, v_nx;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic          ls_q, ls_d, fs_q, fs_d, pend_q, pend_d, err_q, err_d;
  logic          h_wrap, v_wrap, frame_wrap, do_load, cfg_ok;

  assign cfg_in[0] = '{tot: h_total, act: h_active, ss: h_sync_start, se: h_sync_end, pol: hs_pol};
  assign cfg_in[1] = '{tot: v_total, act: v_active, ss: v_sync_start, se: v_sync_end, pol: vs_pol};

  always_comb begin
    h_wrap     = (h_q == shd_q[0].tot - CW'(1));
    v_wrap     = (v_q == shd_q[1].tot - CW'(1));
    h_nx       = h_wrap ? '0 : h_q + CW'(1);
    v_nx       = h_wrap ? (v_wrap ? '0 : v_q + CW'(1)) : v_q;
    frame_wrap = enable && h_wrap && v_wrap;
    do_load    = frame_wrap && (pend_q || cfg_update);
    cfg_ok     = &axis_ok;
  end

  assign pos_nx[0] = h_nx;
  assign pos_nx[1] = v_nx;

  // Per-axis validity, shadow selection and window decode of the next position.
  // The decode uses shd_d so a freshly loaded set already governs the (0,0) cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    assign axis_ok[gi] = (cfg_in[gi].tot >= CW'(2)) &&
                         (cfg_in[gi].act >= CW'(1)) &&
                         (cfg_in[gi].act <= cfg_in[gi].tot) &&
                         (cfg_in[gi].ss  <  cfg_in[gi].se) &&
                         (cfg_in[gi].se  <= cfg_in[gi].tot);
    assign shd_d[gi]   = (do_load && cfg_ok) ? cfg_in[gi] : shd_q[gi];
    assign sync_nx[gi] = (pos_nx[gi] >= shd_d[gi].ss && pos_nx[gi] < shd_d[gi].se) ?
                         shd_d[gi].pol : ~shd_d[gi].pol;
    assign in_act[gi]  = (pos_nx[gi] < shd_d[gi].act);
  end

  always_comb begin
    h_d     = enable ? h_nx       : h_q;
    v_d     = enable ? v_nx       : v_q;
    hsync_d = enable ? sync_nx[0] : hsync_q;
    vsync_d = enable ? sync_nx[1] : vsync_q;
    de_d    = enable ? &in_act    : de_q;
    ls_d    = enable && (h_nx == '0);
    fs_d    = frame_wrap;
    // A request arriving in the wrap cycle itself is consumed immediately.
    pend_d  = do_load ? 1'b0 : (cfg_update ? 1'b1 : pend_q);
    err_d   = do_load ? ~cfg_ok : err_q;
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_q[0] <= '{tot: CW'(H_TOT_D), act: CW'(H_ACT_D), ss: CW'(H_SS_D), se: CW'(H_SE_D), pol: HS_POL_D};
      shd_q[1] <= '{tot: CW'(V_TOT_D), act: CW'(V_ACT_D), ss: CW'(V_SS_D), se: CW'(V_SE_D), pol: VS_POL_D};
      h_q      <= CW'(H_TOT_D - 1);
      v_q      <= CW'(V_TOT_D - 1);
      hsync_q  <= ~HS_POL_D;
      vsync_q  <= ~VS_POL_D;
      de_q     <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shd_q[0] <= shd_d[0];
      shd_q[1] <= shd_d[1];
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
    end
  end

  assign h_count     = h_q;
  assign v_count     = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign cfg_pending = pend_q;
  assign cfg_err     = err_q;

endmodule
